// File: rtl/multi_chan_timer_pkg.sv
// Shared definitions for multi_chan_timer: register word offsets, bit indices
// and the per-channel control/status state record.
package mct_pkg;

    localparam int OFF_STATUS  = 0;
    localparam int OFF_CONTROL = 1;
    localparam int OFF_PERIOD  = 2;
    localparam int OFF_SNAP    = 3;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // Field order matches the CONTROL register layout bits [3:0].
    typedef struct packed {
        logic stop;
        logic start;
        logic cont;
        logic ito;
    } mct_ctrl_t;

    typedef struct packed {
        logic      run;
        logic      to;
        mct_ctrl_t ctrl;
    } mct_chan_state_t;

    function automatic logic [31:0] status_word(input mct_chan_state_t s);
        return {30'd0, s.run, s.to};
    endfunction

endpackage

// File: rtl/multi_chan_timer_if.sv
// Register bus and interrupt outputs of multi_chan_timer.
interface multi_chan_timer_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = $clog2(4*NUM_CH+2)
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq, irq_any
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq, irq_any
    );
endinterface

// File: rtl/multi_chan_timer_channel.sv
// One independent down-counting timer channel: period, counter, run/timeout
// state, control bits and snapshot register.
module mct_channel
    import mct_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_snap,
    input  logic [31:0]      writedata,
    output mct_chan_state_t  state,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap
);
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] counter_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] snap_reg;
    logic             run_reg;
    logic             to_reg;
    mct_ctrl_t        ctrl_reg;
    logic             timeout;

    assign timeout = tick && run_reg && (counter_reg == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_reg <= RST_VAL;
            period_reg  <= RST_VAL;
            snap_reg    <= '0;
            run_reg     <= 1'b0;
            to_reg      <= 1'b0;
            ctrl_reg    <= '0;
        end else begin
            if (wr_period) begin
                period_reg  <= writedata[CNT_W-1:0];
                counter_reg <= writedata[CNT_W-1:0];
            end else if (timeout) begin
                counter_reg <= period_reg;
            end else if (tick && run_reg) begin
                counter_reg <= counter_reg - CNT_W'(1);
            end

            if (wr_control)
                ctrl_reg <= mct_ctrl_t'(writedata[3:0]);

            // Bus writes override the one-shot stop; START beats STOP.
            if (wr_period)
                run_reg <= 1'b0;
            else if (wr_control && writedata[CTL_START])
                run_reg <= 1'b1;
            else if (wr_control && writedata[CTL_STOP])
                run_reg <= 1'b0;
            else if (timeout && !ctrl_reg.cont)
                run_reg <= 1'b0;

            if (timeout)
                to_reg <= 1'b1;
            else if (wr_status)
                to_reg <= 1'b0;

            if (wr_snap)
                snap_reg <= counter_reg;
        end
    end

    assign state  = '{run: run_reg, to: to_reg, ctrl: ctrl_reg};
    assign period = period_reg;
    assign snap   = snap_reg;

endmodule

// File: rtl/multi_chan_timer.sv
// Multi-channel timer top: address decode, registered read mux and optional
// shared prescaler (enabled by MULTI_CHAN_TIMER_PRESCALER_EN).
module multi_chan_timer
    import mct_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input logic               clk,
    input logic               reset_n,
    multi_chan_timer_if.slave bus
);
    localparam int ADDR_W        = $clog2(4*NUM_CH+2);
    localparam int IRQSUM_WORD   = 4*NUM_CH;
    localparam int PRESCALE_WORD = 4*NUM_CH + 1;

    logic [31:0]       word;
    logic              wr_en;
    logic              tick;
    logic [31:0]       prescale_word;
    logic [31:0]       rd_next;
    logic [NUM_CH-1:0] irq_vec;

    mct_chan_state_t   state_a  [NUM_CH];
    logic [CNT_W-1:0]  period_a [NUM_CH];
    logic [CNT_W-1:0]  snap_a   [NUM_CH];

    assign word  = 32'(bus.address);
    assign wr_en = bus.chipselect && !bus.write_n;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            mct_channel #(
                .CNT_W        (CNT_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .tick       (tick),
                .wr_status  (wr_en && (word == 32'(4*gi + OFF_STATUS))),
                .wr_control (wr_en && (word == 32'(4*gi + OFF_CONTROL))),
                .wr_period  (wr_en && (word == 32'(4*gi + OFF_PERIOD))),
                .wr_snap    (wr_en && (word == 32'(4*gi + OFF_SNAP))),
                .writedata  (bus.writedata),
                .state      (state_a[gi]),
                .period     (period_a[gi]),
                .snap       (snap_a[gi])
            );
            assign irq_vec[gi] = state_a[gi].to && state_a[gi].ctrl.ito;
        end
    endgenerate

`ifdef MULTI_CHAN_TIMER_PRESCALER_EN
    logic [7:0] prescale_reg;
    logic [7:0] pre_cnt_reg;

    assign tick          = (pre_cnt_reg == prescale_reg);
    assign prescale_word = {24'd0, prescale_reg};

    // Writing PRESCALE restarts the divider so the new ratio takes effect cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_reg <= '0;
            pre_cnt_reg  <= '0;
        end else if (wr_en && (word == 32'(PRESCALE_WORD))) begin
            prescale_reg <= bus.writedata[7:0];
            pre_cnt_reg  <= '0;
        end else if (tick) begin
            pre_cnt_reg  <= '0;
        end else begin
            pre_cnt_reg  <= pre_cnt_reg + 8'd1;
        end
    end
`else
    assign tick          = 1'b1;
    assign prescale_word = '0;
`endif

    always_comb begin
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (word == 32'(4*c + OFF_STATUS))  rd_next = status_word(state_a[c]);
            if (word == 32'(4*c + OFF_CONTROL)) rd_next = {28'd0, state_a[c].ctrl};
            if (word == 32'(4*c + OFF_PERIOD))  rd_next = 32'(period_a[c]);
            if (word == 32'(4*c + OFF_SNAP))    rd_next = 32'(snap_a[c]);
        end
        if (word == 32'(IRQSUM_WORD))   rd_next = 32'(irq_vec);
        if (word == 32'(PRESCALE_WORD)) rd_next = prescale_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_next;
    end

    assign bus.irq     = irq_vec;
    assign bus.irq_any = |irq_vec;

endmodule

// File: doc/multi_chan_timer.md
MULTI_CHAN_TIMER -- requirements
Module: multi_chan_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL have parameter RESET_PERIOD, default 49999, period and counter value loaded at reset for every channel.
REQ-004 SHALL have localparam ADDR_W = $clog2(4*NUM_CH+2).
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port address, input, ADDR_W, word address.
REQ-008 SHALL have port chipselect, input, 1, slave select.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port irq, output, NUM_CH, per-channel interrupt.
REQ-013 SHALL have port irq_any, output, 1, OR of irq.

Function
REQ-014 Map: channel c at words 4c+0 STATUS (bit0 TO, bit1 RUN), 4c+1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 4c+2 PERIOD, 4c+3 SNAP; word 4*NUM_CH IRQSUM (read-only, irq vector); word 4*NUM_CH+1 PRESCALE.
REQ-015 Write = chipselect && !write_n; reads use address only; readdata SHALL equal the mux output one cycle after address, every cycle; unmapped/undefined bits read 0.
REQ-016 CONTROL write stores bits[3:0]; START=1 sets RUN next cycle; STOP=1 (START=0) clears RUN; START and STOP both 1: START wins.
REQ-017 PERIOD write stores writedata[CNT_W-1:0]; next cycle counter loads PERIOD and RUN clears.
REQ-018 Running counter SHALL decrement by 1 per tick; tick at zero = timeout event: counter reloads PERIOD, TO sets; RUN clears if CONT=0.
REQ-019 PERIOD=0 with CONT=1: timeout on every tick.
REQ-020 STATUS write clears TO; if a timeout event occurs in the same cycle, TO SHALL be set (set dominates).
REQ-021 SNAP write (any data) SHALL capture the live counter; SNAP reads return capture, zero-extended.
REQ-022 irq[c] = TO[c] && ITO[c], combinational from registers; irq_any = |irq.
REQ-023 Channels SHALL be fully independent; simultaneous timeouts on all channels all set TO.
REQ-024 Writes to IRQSUM SHALL be ignored.

Reset
REQ-025 On reset_n low: counters and PERIOD = RESET_PERIOD[CNT_W-1:0]; RUN, TO, CONTROL, SNAP, PRESCALE, prescale counter, readdata = 0; irq = 0.
REQ-026 Reset asserted mid-count SHALL abort immediately; no timeout is recorded after release until START.

Configuration
REQ-027 Macro MULTI_CHAN_TIMER_PRESCALER_EN defined: PRESCALE holds 8-bit value P; a shared free-running prescale counter SHALL generate one tick every P+1 clk cycles; it restarts at 0 when PRESCALE is written.
REQ-028 Macro undefined: tick every clk; PRESCALE reads 0 and writes are ignored; no prescale logic synthesised.

Structure
REQ-029 Package mct_pkg SHALL hold register word offsets, CONTROL/STATUS bit indices, and a channel-state typedef.
REQ-030 Per-channel logic SHALL be sub-module mct_channel, instantiated NUM_CH times by generate; top holds decode, read mux, and prescaler.

Verification
REQ-031 Ch0 PERIOD=4, CONTROL=0x7 -> TO at 5-cycle intervals, irq[0]=1, irq_any=1; STATUS write -> irq[0]=0 next cycle.
REQ-032 Ch1 PERIOD=3, CONTROL=0x4 (one-shot) -> one timeout, RUN=0, counter=3, no further TO after clear.
REQ-033 Ch2 running with PERIOD=100, write PERIOD=10 -> RUN=0, counter=10 next cycle; SNAP write reads 10.
REQ-034 STATUS clear coincident with timeout -> TO remains 1; CONTROL=0xC -> RUN=1.
REQ-035 With MULTI_CHAN_TIMER_PRESCALER_EN, PRESCALE=3, PERIOD=1, CONT -> timeout every 8 clk; without macro -> every 2 clk, PRESCALE reads 0.
REQ-036 Assert reset_n mid-count -> all registers at REQ-025 values; IRQSUM reads 0.
